// File: rtl/speaker_pkg.sv
// Shared constants and helpers for the speaker tone source: frame divider width,
// the update index inside the frame, and the volume-to-amplitude table.
package speaker_pkg;

   localparam int DIV_W = 9;
   localparam logic [DIV_W-1:0] LRCK_UPD_IDX = 9'd255;

   localparam logic [15:0] AMP_VOL0 = 16'h0000;
   localparam logic [15:0] AMP_VOL1 = 16'h0800;
   localparam logic [15:0] AMP_VOL2 = 16'h1000;
   localparam logic [15:0] AMP_VOL3 = 16'h2000;
   localparam logic [15:0] AMP_VOL4 = 16'h4000;
   localparam logic [15:0] AMP_SAT  = 16'h7FFF;

   typedef struct packed {
      logic phase;
      logic silent;
   } chan_state_t;

   function automatic logic [15:0] vol_to_amp(input logic [2:0] vol);
      logic [15:0] amp;
      case (vol)
         3'd0:    amp = AMP_VOL0;
         3'd1:    amp = AMP_VOL1;
         3'd2:    amp = AMP_VOL2;
         3'd3:    amp = AMP_VOL3;
         3'd4:    amp = AMP_VOL4;
         default: amp = AMP_SAT;
      endcase
      return amp;
   endfunction

   // High phase gives +amp, low phase gives the two's-complement negative.
   function automatic logic [15:0] signed_tone(input logic [15:0] amp, input logic phase);
      return phase ? amp : (~amp + 16'd1);
   endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave channel: half-period counter, phase bit and silence detect.
// A note_div of 0 or 1 parks the channel at count 0, phase 0.
module tone_channel
   import speaker_pkg::*;
#(
   parameter int CNT_W = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] note_div,
   output chan_state_t      state
);

   logic [CNT_W-1:0] cnt;
   logic             phase;
   logic             silent;

   assign silent = (note_div <= CNT_W'(1));

   // ">=" rather than "==" so a period shortened below the running count
   // wraps on the very next edge instead of running to counter overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (silent) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt >= note_div - CNT_W'(1)) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt   <= cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state        = '0;
      state.phase  = phase;
      state.silent = silent;
   end

endmodule

// File: rtl/speaker_tone_source.sv
// Two-channel square-wave source for an I2S-style DAC: derives mclk/sck/lrck
// from a 9-bit divider and updates both samples once per frame at lrck rise.
module speaker_tone_source
   import speaker_pkg::*;
#(
   parameter int CNT_W = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] note_div_left,
   input  logic [CNT_W-1:0] note_div_right,
   input  logic [2:0]       volume,
   input  logic             mute,
   output logic             audio_mclk,
   output logic             audio_sck,
   output logic             audio_lrck,
   output logic [15:0]      audio_in_left,
   output logic [15:0]      audio_in_right
);

   logic [DIV_W-1:0] div_cnt;
   chan_state_t      st_left;
   chan_state_t      st_right;
   logic             phase_left;
   logic             phase_right;
   logic [15:0]      amp;
   logic [15:0]      val_left;
   logic [15:0]      val_right;
   logic             upd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) div_cnt <= '0;
      else     div_cnt <= div_cnt + DIV_W'(1);
   end

   // Clock outputs are plain taps of the divider register, so lrck edges land
   // exactly where the low four bits wrap, i.e. on sck falling edges.
   assign audio_mclk = div_cnt[1];
   assign audio_sck  = div_cnt[3];
   assign audio_lrck = div_cnt[8];

   tone_channel #(.CNT_W(CNT_W)) u_left (
      .clk      (clk),
      .rst      (rst),
      .note_div (note_div_left),
      .state    (st_left)
   );

   tone_channel #(.CNT_W(CNT_W)) u_right (
      .clk      (clk),
      .rst      (rst),
      .note_div (note_div_right),
      .state    (st_right)
   );

   assign phase_left  = st_left.phase;
   assign phase_right = st_right.phase;
   assign amp         = vol_to_amp(volume);
   assign upd         = (div_cnt == LRCK_UPD_IDX);

   always_comb begin
      val_left  = 16'h0000;
      val_right = 16'h0000;
      if (!mute && (amp != 16'h0000)) begin
         if (!st_left.silent)  val_left  = signed_tone(amp, phase_left);
         if (!st_right.silent) val_right = signed_tone(amp, phase_right);
      end
   end

   // Samples move only as lrck rises, leaving them steady across the fall
   // where the serializer latches them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         audio_in_left  <= 16'h0000;
         audio_in_right <= 16'h0000;
      end else if (upd) begin
         audio_in_left  <= val_left;
         audio_in_right <= val_right;
      end
   end

endmodule

// File: tb/tb_speaker_tone_source.sv
// Directed bench for speaker_tone_source: clocks, tone words, volume table,
// mute, silence, short-period retarget, mid-frame reset and frame stability.
module tb_speaker_tone_source;

   localparam int CNT_W = 22;

   logic             clk = 1'b0;
   logic             rst;
   logic [CNT_W-1:0] note_div_left;
   logic [CNT_W-1:0] note_div_right;
   logic [2:0]       volume;
   logic             mute;
   logic             audio_mclk;
   logic             audio_sck;
   logic             audio_lrck;
   logic [15:0]      audio_in_left;
   logic [15:0]      audio_in_right;

   speaker_tone_source #(.CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .note_div_left  (note_div_left),
      .note_div_right (note_div_right),
      .volume         (volume),
      .mute           (mute),
      .audio_mclk     (audio_mclk),
      .audio_sck      (audio_sck),
      .audio_lrck     (audio_lrck),
      .audio_in_left  (audio_in_left),
      .audio_in_right (audio_in_right)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int k;

   int bad_mclk, bad_sck, bad_lrck, bad_align, bad_n32, bad_left, bad_right;
   int bad_upd, bad_half, n_half, lrck_rises, sck_falls, last_chg, early;
   int nchg, bad_chg, bad_cap, frames, kb;
   logic        prev_sck, prev_lrck, have_pre;
   logic [15:0] prev_left, prev_right, exp_left, pre_l, pre_r, cap_l, cap_r;
   logic [8:0]  kbits;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic run_to(input int t);
      while (k < t) tick();
   endtask

   // After release, the n-th following rising edge leaves div_cnt = n.
   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      k = 0;
   endtask

   function automatic logic [15:0] tone_word(input int u, input int div, input logic [15:0] amp);
      return ((((u - 1) / div) % 2) == 1) ? amp : (~amp + 16'd1);
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      note_div_left  = '0;
      note_div_right = '0;
      volume = 3'd0;
      mute   = 1'b0;
      k = 0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_mclk",  audio_mclk, 0);
      check("rst_sck",   audio_sck, 0);
      check("rst_lrck",  audio_lrck, 0);
      check("rst_left",  audio_in_left, 0);
      check("rst_right", audio_in_right, 0);

      // clocks plus a left tone (half-period 10000), right silent
      note_div_left  = 10000;
      note_div_right = 1;
      volume = 3'd3;
      do_reset();
      {bad_mclk, bad_sck, bad_lrck, bad_align, bad_n32, bad_left, bad_right} = '0;
      {bad_upd, bad_half, n_half, lrck_rises, sck_falls} = '0;
      last_chg = -1;
      prev_sck = 1'b0;
      prev_lrck = 1'b0;
      prev_left = 16'h0000;
      while (k < 31000) begin
         tick();
         kbits = k[8:0];
         if (audio_mclk !== kbits[1]) bad_mclk++;
         if (audio_sck  !== kbits[3]) bad_sck++;
         if (audio_lrck !== kbits[8]) bad_lrck++;
         if (prev_sck && !audio_sck) sck_falls++;
         if ((audio_lrck !== prev_lrck) && !(prev_sck && !audio_sck)) bad_align++;
         if (audio_lrck && !prev_lrck) begin
            if (lrck_rises > 0 && sck_falls != 32) bad_n32++;
            sck_falls = 0;
            lrck_rises++;
         end
         exp_left = (k < 256) ? 16'h0000 : tone_word(256 + ((k - 256) / 512) * 512, 10000, 16'h2000);
         if (audio_in_left !== exp_left) bad_left++;
         if (audio_in_right !== 16'h0000) bad_right++;
         if (audio_in_left !== prev_left) begin
            if (!(audio_lrck && !prev_lrck)) bad_upd++;
            if (prev_left != 16'h0000) begin
               if (last_chg >= 0) begin
                  if ((k - last_chg - 10000) > 512 || (k - last_chg - 10000) < -512) bad_half++;
                  n_half++;
               end
               last_chg = k;
            end
         end
         prev_sck  = audio_sck;
         prev_lrck = audio_lrck;
         prev_left = audio_in_left;
      end
      check("mclk_wave",       bad_mclk, 0);
      check("sck_wave",        bad_sck, 0);
      check("lrck_wave",       bad_lrck, 0);
      check("lrck_on_sck_fall", bad_align, 0);
      check("sck_per_lrck_32", bad_n32, 0);
      check("lrck_rises",      lrck_rises, 61);
      check("tone_left_words", bad_left, 0);
      check("tone_right_silent", bad_right, 0);
      check("left_upd_at_rise", bad_upd, 0);
      check("half_period",     bad_half, 0);
      check("half_count",      n_half, 2);

      // saturation, mute and the volume table (left 3000, right 2000)
      note_div_left  = 3000;
      note_div_right = 2000;
      volume = 3'd7;
      mute   = 1'b0;
      do_reset();
      run_to(256);
      check("sat_l_256", audio_in_left, 16'h8001);
      check("sat_r_256", audio_in_right, 16'h8001);
      run_to(3327);
      check("sat_l_hold", audio_in_left, 16'h8001);
      check("sat_r_hold", audio_in_right, 16'h7FFF);
      run_to(3328);
      check("sat_l_3328", audio_in_left, 16'h7FFF);
      check("sat_r_3328", audio_in_right, 16'h7FFF);
      run_to(4352);
      check("sat_l_4352", audio_in_left, 16'h7FFF);
      check("sat_r_4352", audio_in_right, 16'h8001);
      run_to(4500);
      mute = 1'b1;
      run_to(4863);
      check("mute_hold_l", audio_in_left, 16'h7FFF);
      check("mute_hold_r", audio_in_right, 16'h8001);
      run_to(4864);
      check("mute_l", audio_in_left, 16'h0000);
      check("mute_r", audio_in_right, 16'h0000);
      run_to(5000);
      mute = 1'b0;
      volume = 3'd1;
      run_to(5376);
      check("vol1_l", audio_in_left, 16'h0800);
      check("vol1_r", audio_in_right, 16'hF800);
      run_to(5500);
      volume = 3'd0;
      run_to(5888);
      check("vol0_l", audio_in_left, 16'h0000);
      check("vol0_r", audio_in_right, 16'h0000);
      run_to(6000);
      volume = 3'd2;
      run_to(6400);
      check("vol2_l", audio_in_left, 16'hF000);
      check("vol2_r", audio_in_right, 16'h1000);
      run_to(6500);
      volume = 3'd4;
      run_to(6912);
      check("vol4_l", audio_in_left, 16'hC000);
      check("vol4_r", audio_in_right, 16'h4000);
      run_to(7000);
      volume = 3'd5;
      run_to(7424);
      check("vol5_l", audio_in_left, 16'h8001);
      check("vol5_r", audio_in_right, 16'h7FFF);

      // silence on the left, right retargeted 200000 -> 50 mid-count
      note_div_left  = 0;
      note_div_right = 200000;
      volume = 3'd3;
      do_reset();
      run_to(256);
      check("sil_l_256", audio_in_left, 16'h0000);
      check("ret_r_256", audio_in_right, 16'hE000);
      run_to(1000);
      check("ret_phase_before", dut.phase_right, 0);
      note_div_right = 50;
      run_to(1001);
      check("ret_phase_toggle", dut.phase_right, 1);
      run_to(1050);
      check("ret_phase_hold", dut.phase_right, 1);
      run_to(1051);
      check("ret_phase_50", dut.phase_right, 0);
      run_to(2304);
      check("ret_r_2304", audio_in_right, 16'h2000);
      check("sil_l_2304", audio_in_left, 16'h0000);
      run_to(4352);
      check("ret_r_4352", audio_in_right, 16'hE000);
      run_to(4400);
      note_div_right = 1;
      run_to(4401);
      check("sil_r_phase", dut.phase_right, 0);
      run_to(4864);
      check("sil_r_4864", audio_in_right, 16'h0000);
      run_to(5376);
      check("sil_r_5376", audio_in_right, 16'h0000);
      check("sil_l_5376", audio_in_left, 16'h0000);

      // mid-frame asynchronous reset at div_cnt = 300
      note_div_left  = 2000;
      note_div_right = 2000;
      volume = 3'd3;
      do_reset();
      run_to(300);
      check("pre_rst_lrck", audio_lrck, 1);
      check("pre_rst_sck",  audio_sck, 1);
      check("pre_rst_left", audio_in_left, 16'hE000);
      #2;
      rst = 1'b1;
      #1;
      check("arst_mclk",  audio_mclk, 0);
      check("arst_sck",   audio_sck, 0);
      check("arst_lrck",  audio_lrck, 0);
      check("arst_left",  audio_in_left, 0);
      check("arst_right", audio_in_right, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      k = 0;
      early = 0;
      while (k < 255) begin
         tick();
         if (audio_lrck !== 1'b0) early++;
      end
      check("arst_no_early_lrck", early, 0);
      tick();
      check("arst_lrck_256", audio_lrck, 1);

      // 64 frames of capture at every lrck fall with changing volume/mute
      note_div_left  = 3000;
      note_div_right = 700;
      volume = 3'd3;
      mute   = 1'b0;
      do_reset();
      {nchg, bad_chg, bad_cap, frames} = '0;
      have_pre   = 1'b0;
      prev_lrck  = 1'b0;
      prev_left  = 16'h0000;
      prev_right = 16'h0000;
      cap_l = 16'h0000;
      cap_r = 16'h0000;
      pre_l = 16'h0000;
      pre_r = 16'h0000;
      while (k < 64 * 512 + 200) begin
         tick();
         kb = k % 512;
         if (kb == 100) volume = 3'((k / 512) % 8);
         if (kb == 400) mute = ((k / 512) % 5 == 0);
         if ((audio_in_left !== prev_left) || (audio_in_right !== prev_right)) begin
            nchg++;
            if (kb != 256) bad_chg++;
         end
         if (kb == 384) begin
            pre_l = audio_in_left;
            pre_r = audio_in_right;
            have_pre = 1'b1;
         end
         if (prev_lrck && !audio_lrck) begin
            cap_l = audio_in_left;
            cap_r = audio_in_right;
            if (have_pre && ((cap_l !== pre_l) || (cap_r !== pre_r))) bad_cap++;
            frames++;
         end
         if (kb == 128 && frames > 0) begin
            if ((audio_in_left !== cap_l) || (audio_in_right !== cap_r)) bad_cap++;
         end
         prev_lrck  = audio_lrck;
         prev_left  = audio_in_left;
         prev_right = audio_in_right;
      end
      check("stab_frames",     frames, 64);
      check("stab_change_pos", bad_chg, 0);
      check("stab_capture",    bad_cap, 0);
      check("stab_activity",   (nchg > 16), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
